// File: rtl/imm_pkg.sv
// Shared decode constants for the immediate generator: format codes and RV opcodes.
package imm_pkg;

    typedef logic [2:0] imm_fmt_t;

    // Immediate format codes as seen on out_fmt
    localparam imm_fmt_t IMM_FMT_NONE     = 3'd0;
    localparam imm_fmt_t IMM_FMT_I        = 3'd1;
    localparam imm_fmt_t IMM_FMT_S        = 3'd2;
    localparam imm_fmt_t IMM_FMT_B        = 3'd3;
    localparam imm_fmt_t IMM_FMT_U        = 3'd4;
    localparam imm_fmt_t IMM_FMT_J        = 3'd5;
    localparam imm_fmt_t IMM_FMT_SHAMT    = 3'd6;
    localparam imm_fmt_t IMM_FMT_CSR_ZIMM = 3'd7;

    // Base-ISA major opcodes (instr[6:0]); all end in 2'b11
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 values selecting the shift-immediate forms
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus of the immediate generator: input stream (instr+tag) and output stream (result+tag).
interface imm_gen_pipe_if #(
    parameter int XLEN      = 32,
    parameter int INS_WIDTH = 32,
    parameter int TAG_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INS_WIDTH-1:0] in_instr;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [2:0]           out_fmt;
    logic                 out_illegal;
    logic [TAG_WIDTH-1:0] out_tag;

    // Producer of instructions / consumer of results
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // The immediate generator itself
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction -> extended immediate, format, illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);
    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic       is_shift_s;

    assign opcode_s   = instr[6:0];
    assign f3_s       = instr[14:12];
    assign is_shift_s = (f3_s == F3_SLL) || (f3_s == F3_SRX);

    // Select the immediate layout by opcode; unknown opcodes (incl. instr[1:0]!=11) are illegal
    always_comb begin
        imm     = '0;
        fmt     = IMM_FMT_NONE;
        illegal = 1'b0;
        case (opcode_s)
            OPC_OP_IMM: begin
                if (is_shift_s) begin
                    fmt = IMM_FMT_SHAMT;
                    // funct7 bits above the shamt field never reach the immediate
                    if (XLEN == 64) begin
                        imm = XLEN'(instr[25:20]);
                    end else begin
                        imm = XLEN'(instr[24:20]);
                    end
                end else begin
                    fmt = IMM_FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end else if (is_shift_s) begin
                    fmt = IMM_FMT_SHAMT;
                    imm = XLEN'(instr[24:20]);
                end else begin
                    fmt = IMM_FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = IMM_FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_STORE: begin
                fmt = IMM_FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = IMM_FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_JAL: begin
                fmt = IMM_FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = IMM_FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_SYSTEM: begin
                if (f3_s[2]) begin
                    fmt = IMM_FMT_CSR_ZIMM;
                    imm = XLEN'(instr[19:15]);
                end else if (f3_s != 3'b000) begin
                    fmt = IMM_FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end else begin
                    fmt = IMM_FMT_NONE;
                end
            end
            OPC_OP, OPC_FENCE: begin
                fmt = IMM_FMT_NONE;
            end
            OPC_OP_32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end else begin
                    fmt = IMM_FMT_NONE;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid (output reg OR + skid reg SR), FIFO ordered.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INS_WIDTH = 32,
    parameter int TAG_WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    // One entry = {imm, fmt, illegal, tag}
    localparam int EW = XLEN + 3 + 1 + TAG_WIDTH;

    logic [INS_WIDTH-1:0] instr_s;
    logic [XLEN-1:0]      dec_imm_s;
    imm_fmt_t             dec_fmt_s;
    logic                 dec_ill_s;
    logic [EW-1:0]        new_data_s;
    logic                 accept_s;

    logic          or_valid_q, or_valid_d;
    logic [EW-1:0] or_data_q,  or_data_d;
    logic          sr_valid_q, sr_valid_d;
    logic [EW-1:0] sr_data_q,  sr_data_d;

    assign instr_s = bus.in_instr;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr_s),
        .imm     (dec_imm_s),
        .fmt     (dec_fmt_s),
        .illegal (dec_ill_s)
    );

    assign new_data_s = {dec_imm_s, dec_fmt_s, dec_ill_s, bus.in_tag};

    // in_ready depends only on a flop, so it never combinationally follows out_ready
    assign bus.in_ready  = ~sr_valid_q;
    assign accept_s      = bus.in_valid & ~sr_valid_q;
    assign bus.out_valid = or_valid_q;
    assign {bus.out_imm, bus.out_fmt, bus.out_illegal, bus.out_tag} = or_data_q;

    // Next-state of OR/SR: drain SR first, else place a new entry in OR or spill it into SR
    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        sr_valid_d = sr_valid_q;
        sr_data_d  = sr_data_q;
        if (sr_valid_q) begin
            // SR full implies OR full and no accept this cycle
            if (bus.out_ready) begin
                or_data_d  = sr_data_q;
                sr_valid_d = 1'b0;
            end else begin
                or_valid_d = or_valid_q;
            end
        end else if (accept_s) begin
            if (~or_valid_q | bus.out_ready) begin
                or_valid_d = 1'b1;
                or_data_d  = new_data_s;
            end else begin
                sr_valid_d = 1'b1;
                sr_data_d  = new_data_s;
            end
        end else if (bus.out_ready) begin
            or_valid_d = 1'b0;
        end else begin
            or_valid_d = or_valid_q;
        end
    end

    // State registers; synchronous reset drops every held entry and clears the payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            sr_valid_q <= 1'b0;
            sr_data_q  <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            sr_valid_q <= sr_valid_d;
            sr_data_q  <= sr_data_d;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vectors at XLEN=32 and XLEN=64, backpressure, mid-stream reset, random stress.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .INS_WIDTH(32), .TAG_WIDTH(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .INS_WIDTH(32), .TAG_WIDTH(32)) b64 ();

    // The 64-bit instance sees exactly the same stimulus as the 32-bit one
    assign b64.in_valid  = b32.in_valid;
    assign b64.in_instr  = b32.in_instr;
    assign b64.in_tag    = b32.in_tag;
    assign b64.out_ready = b32.out_ready;

    imm_gen_pipe #(.XLEN(32), .INS_WIDTH(32), .TAG_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .INS_WIDTH(32), .TAG_WIDTH(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    int tag_ctr  = 16;

    typedef struct {
        logic [31:0] tag;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [6:0] ops [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                             7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h13};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: the immediate rules written as shifts/masks on the sign-extended instruction word
    function automatic void ref_model(input logic [31:0] ins, input bit x64,
                                      output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
        logic [63:0] u;
        logic [63:0] s;
        logic [2:0]  f3;
        u   = {32'd0, ins};
        s   = {{32{ins[31]}}, ins};
        f3  = ins[14:12];
        imm = 64'd0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h1B: begin
                if (ins[6:0] == 7'h1B && !x64) ill = 1'b1;
                else if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = 3'd6;
                    imm = (u >> 20) & ((ins[6:0] == 7'h13 && x64) ? 64'd63 : 64'd31);
                end else begin
                    fmt = 3'd1;
                    imm = 64'($signed(s) >>> 20);
                end
            end
            7'h03, 7'h67: begin fmt = 3'd1; imm = 64'($signed(s) >>> 20); end
            7'h23: begin fmt = 3'd2; imm = (64'($signed(s) >>> 25) << 5) | ((u >> 7) & 64'd31); end
            7'h63: begin
                fmt = 3'd3;
                imm = (64'($signed(s) >>> 31) << 12) | (((u >> 7) & 64'd1) << 11)
                    | (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1);
            end
            7'h6F: begin
                fmt = 3'd5;
                imm = (64'($signed(s) >>> 31) << 20) | (((u >> 12) & 64'hFF) << 12)
                    | (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'h3FF) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; imm = 64'($signed(s) >>> 12) << 12; end
            7'h73: begin
                if (f3 >= 3'd4) begin fmt = 3'd7; imm = (u >> 15) & 64'd31; end
                else if (f3 != 3'd0) begin fmt = 3'd1; imm = 64'($signed(s) >>> 20); end
                else fmt = 3'd0;
            end
            7'h33, 7'h0F: fmt = 3'd0;
            7'h3B: if (!x64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(7, 0) != 0) r[6:0] = ops[$urandom_range(13, 0)];
        return r;
    endfunction

    // Scoreboard: push model results on input transfers, compare FIFO-ordered on output transfers
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else if (mon_en) begin
            if (b32.out_valid && b32.out_ready) begin
                check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_val("sb_tag32", 64'(b32.out_tag), 64'(mon_e.tag));
                    check_val("sb_imm32", 64'(b32.out_imm), mon_e.imm32);
                    check_val("sb_fmt32", 64'(b32.out_fmt), 64'(mon_e.fmt32));
                    check_val("sb_ill32", 64'(b32.out_illegal), 64'(mon_e.ill32));
                    check_val("sb_valid64", 64'(b64.out_valid), 64'd1);
                    check_val("sb_tag64", 64'(b64.out_tag), 64'(mon_e.tag));
                    check_val("sb_imm64", b64.out_imm, mon_e.imm64);
                    check_val("sb_fmt64", 64'(b64.out_fmt), 64'(mon_e.fmt64));
                    check_val("sb_ill64", 64'(b64.out_illegal), 64'(mon_e.ill64));
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                mon_e.tag = b32.in_tag;
                ref_model(b32.in_instr, 1'b0, mon_e.imm32, mon_e.fmt32, mon_e.ill32);
                mon_e.imm32 = {32'd0, mon_e.imm32[31:0]};
                ref_model(b32.in_instr, 1'b1, mon_e.imm64, mon_e.fmt64, mon_e.ill64);
                sb_q.push_back(mon_e);
            end
        end
    end

    task automatic apply(input logic [31:0] ins, input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                         input logic [63:0] i64, input logic [2:0] f64, input logic l64);
        @(posedge clk); #1;
        b32.in_valid  = 1'b1;
        b32.in_instr  = ins;
        b32.in_tag    = 32'(tag_ctr);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check_val($sformatf("dir_valid_%h", ins), 64'(b32.out_valid), 64'd1);
        check_val($sformatf("dir_tag_%h", ins), 64'(b32.out_tag), 64'(tag_ctr));
        check_val($sformatf("dir_imm32_%h", ins), 64'(b32.out_imm), 64'(i32));
        check_val($sformatf("dir_fmt32_%h", ins), 64'(b32.out_fmt), 64'(f32));
        check_val($sformatf("dir_ill32_%h", ins), 64'(b32.out_illegal), 64'(l32));
        check_val($sformatf("dir_imm64_%h", ins), b64.out_imm, i64);
        check_val($sformatf("dir_fmt64_%h", ins), 64'(b64.out_fmt), 64'(f64));
        check_val($sformatf("dir_ill64_%h", ins), 64'(b64.out_illegal), 64'(l64));
        tag_ctr++;
    endtask

    logic        in_x, out_x, held_valid;
    logic [31:0] held_tag, held_imm;
    int          inflight;
    logic [31:0] got_tags[$];

    initial begin
        rst_n         = 1'b0;
        b32.in_valid  = 1'b1;          // presented during reset, must be discarded
        b32.in_instr  = 32'h12345037;
        b32.in_tag    = 32'hDEAD;
        b32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check_val("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check_val("rst_out_imm", 64'(b32.out_imm), 64'd0);
        check_val("rst_out_fmt", 64'(b32.out_fmt), 64'd0);
        check_val("rst_out_ill", 64'(b32.out_illegal), 64'd0);
        check_val("rst_out_tag", 64'(b32.out_tag), 64'd0);
        b32.in_valid = 1'b0;
        rst_n        = 1'b1;
        mon_en       = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_idle", 64'(b32.out_valid), 64'd0);

        // Directed decode vectors: instr, XLEN=32 result, XLEN=64 result
        apply(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        apply(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        apply(32'h12345037, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0);
        apply(32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0);
        apply(32'h01F01013, 32'd31,       3'd6, 1'b0, 64'd31,               3'd6, 1'b0);
        apply(32'h40305013, 32'd3,        3'd6, 1'b0, 64'd3,                3'd6, 1'b0);
        apply(32'h03F01013, 32'd31,       3'd6, 1'b0, 64'd63,               3'd6, 1'b0);
        apply(32'h0000001B, 32'd0,        3'd0, 1'b1, 64'd0,                3'd1, 1'b0);
        apply(32'h00000000, 32'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
        apply(32'hFFFFFFFF, 32'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b1);
        apply(32'h00005073, 32'd0,        3'd7, 1'b0, 64'd0,                3'd7, 1'b0);
        apply(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
        apply(32'h300022F3, 32'h00000300, 3'd1, 1'b0, 64'h0000000000000300, 3'd1, 1'b0);
        apply(32'h00B50533, 32'd0,        3'd0, 1'b0, 64'd0,                3'd0, 1'b0);
        apply(32'h0000003B, 32'd0,        3'd0, 1'b1, 64'd0,                3'd0, 1'b0);
        @(posedge clk); #1;
        check_val("dir_drained", 64'(b32.out_valid), 64'd0);

        // Backpressure: tags 1..5 streamed, consumer stalls on cycles 2-4
        b32.in_valid  = 1'b1;
        b32.in_tag    = 32'd1;
        b32.in_instr  = rand_instr();
        b32.out_ready = 1'b1;
        inflight      = 0;
        held_valid    = 1'b0;
        held_tag      = 32'd0;
        held_imm      = 32'd0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            check_val($sformatf("bp_in_ready_c%0d", cyc), 64'(b32.in_ready), 64'(inflight < 2));
            if (held_valid) begin
                check_val($sformatf("bp_hold_tag_c%0d", cyc), 64'(b32.out_tag), 64'(held_tag));
                check_val($sformatf("bp_hold_imm_c%0d", cyc), 64'(b32.out_imm), 64'(held_imm));
            end
            held_valid = b32.out_valid && !b32.out_ready;
            held_tag   = b32.out_tag;
            held_imm   = b32.out_imm;
            in_x       = b32.in_valid && b32.in_ready;
            out_x      = b32.out_valid && b32.out_ready;
            if (out_x) got_tags.push_back(b32.out_tag);
            inflight = inflight + int'(in_x) - int'(out_x);
            @(posedge clk); #1;
            if (in_x) begin
                if (b32.in_tag == 32'd5) begin
                    b32.in_valid = 1'b0;
                end else begin
                    b32.in_tag   = b32.in_tag + 32'd1;
                    b32.in_instr = rand_instr();
                end
            end
            b32.out_ready = !((cyc + 1 >= 2) && (cyc + 1 <= 4));
        end
        check_val("bp_count", 64'(got_tags.size()), 64'd5);
        for (int i = 0; i < got_tags.size(); i++) begin
            check_val($sformatf("bp_order_%0d", i), 64'(got_tags[i]), 64'(i + 1));
        end

        // Reset with OR and SR both holding entries
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1;
        b32.in_tag    = 32'h100;
        b32.in_instr  = rand_instr();
        @(posedge clk); #1;
        b32.in_tag   = 32'h101;
        b32.in_instr = rand_instr();
        @(posedge clk); #1;
        check_val("mr_full_in_ready", 64'(b32.in_ready), 64'd0);
        check_val("mr_full_out_tag", 64'(b32.out_tag), 64'h100);
        rst_n      = 1'b0;
        b32.in_tag = 32'h102;
        @(posedge clk); #1;
        check_val("mr_out_valid", 64'(b32.out_valid), 64'd0);
        check_val("mr_in_ready", 64'(b32.in_ready), 64'd1);
        check_val("mr_out_tag", 64'(b32.out_tag), 64'd0);
        rst_n         = 1'b1;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("mr_no_replay", 64'(b32.out_valid), 64'd0);
        b32.in_valid = 1'b1;
        b32.in_tag   = 32'h1AB;
        b32.in_instr = 32'h12345037;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check_val("mr_new_valid", 64'(b32.out_valid), 64'd1);
        check_val("mr_new_tag", 64'(b32.out_tag), 64'h1AB);
        check_val("mr_new_imm", 64'(b32.out_imm), 64'h12345000);
        @(posedge clk); #1;
        check_val("mr_new_alone", 64'(b32.out_valid), 64'd0);

        // Random stress: valid held until accepted, random consumer stalls
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_x = b32.in_valid && b32.in_ready;
            @(posedge clk); #1;
            if (!b32.in_valid || in_x) begin
                b32.in_valid = ($urandom_range(3, 0) != 0);
                b32.in_instr = rand_instr();
                b32.in_tag   = 32'(tag_ctr);
                tag_ctr++;
            end
            b32.out_ready = ($urandom_range(3, 0) != 0);
        end
        @(negedge clk);
        in_x = b32.in_valid && b32.in_ready;
        @(posedge clk); #1;
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("stress_drained_valid", 64'(b32.out_valid), 64'd0);
        check_val("stress_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
